// File: rtl/bcd_edit_pkg.sv
// Shared types and BCD helpers for the BCD field editor.
package bcd_edit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_DONE   = 2'd2,
    ST_CANCEL = 2'd3
  } state_t;

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return 7'(7'(b[7:4]) * 7'd10 + 7'(b[3:0]));
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  function automatic logic is_valid_bcd(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_field_editor_btn_repeat.sv
// Rising-edge detect plus tick-driven auto-repeat for one adjust button.
module btn_repeat #(
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  input  logic other,
  input  logic enable,
  input  logic clear,
  output logic act_c
);

  localparam int unsigned MAXC = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  logic          prev;
  logic          rep;
  logic [CW-1:0] cnt;
  logic [CW-1:0] limit;
  logic          run;
  logic          fire;

  // Counting only while this button alone is held in edit mode
  assign run   = enable & btn & ~other & ~clear;
  assign limit = rep ? CW'(REPEAT_RATE - 1) : CW'(REPEAT_DELAY - 1);
  assign fire  = run & tick & (cnt == limit);
  assign act_c = enable & ~other & ((btn & ~prev) | fire);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b0;
      rep  <= 1'b0;
      cnt  <= '0;
    end else begin
      prev <= btn;
      if (!run) begin
        rep <= 1'b0;
        cnt <= '0;
      end else if (tick) begin
        if (cnt == limit) begin
          rep <= 1'b1;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/bcd_field_editor.sv
// Push-button editor for a packed multi-field BCD value with commit/cancel.
module bcd_field_editor
  import bcd_edit_pkg::*;
#(
  parameter int unsigned               NUM_FIELDS   = 3,
  parameter logic [8*NUM_FIELDS-1:0]   FIELD_MAX    = 24'h235959,
  parameter logic [8*NUM_FIELDS-1:0]   FIELD_MIN    = 24'h000000,
  parameter int unsigned               REPEAT_DELAY = 500,
  parameter int unsigned               REPEAT_RATE  = 100
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          start,
  input  logic [8*NUM_FIELDS-1:0]       load_data,
  input  logic                          bt_up,
  input  logic                          bt_down,
  input  logic                          bt_left,
  input  logic                          bt_right,
  input  logic                          bt_ok,
  input  logic                          bt_cancel,
  output logic [8*NUM_FIELDS-1:0]       edit_data,
  output logic [$clog2(2*NUM_FIELDS)-1:0] cursor,
  output logic                          editing,
  output logic                          done,
  output logic                          cancelled
);

  localparam int unsigned W  = 8 * NUM_FIELDS;
  localparam int unsigned CW = $clog2(2 * NUM_FIELDS);
  localparam logic [CW-1:0] LAST = CW'(2 * NUM_FIELDS - 1);

  state_t        state, state_d;
  logic [W-1:0]  snap, snap_d, data_d;
  logic [CW-1:0] cursor_d;
  logic          prev_l, prev_r, prev_ok, prev_cn;
  logic          l_e, r_e, ok_e, cn_e, nav, move;
  logic          up_act, dn_act;

  // Out-of-range or non-BCD fields fall back to their minimum
  function automatic logic [W-1:0] sanitise(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < int'(NUM_FIELDS); i++) begin
      if (!is_valid_bcd(d[8*i +: 8]) || (d[8*i +: 8] < FIELD_MIN[8*i +: 8]) ||
          (d[8*i +: 8] > FIELD_MAX[8*i +: 8]))
        r[8*i +: 8] = FIELD_MIN[8*i +: 8];
    end
    return r;
  endfunction

  // Step the field under the cursor by one unit or ten, wrapping at the limits
  function automatic logic [W-1:0] adjust(input logic [W-1:0] d, input logic [CW-1:0] cur,
                                          input logic up);
    logic [W-1:0] r;
    logic [7:0]   v, mn, mx, nv;
    r = d;
    for (int i = 0; i < int'(NUM_FIELDS); i++) begin
      v  = {1'b0, bcd2bin(d[8*i +: 8])};
      mn = {1'b0, bcd2bin(FIELD_MIN[8*i +: 8])};
      mx = {1'b0, bcd2bin(FIELD_MAX[8*i +: 8])};
      nv = v;
      if (up) begin
        if (!cur[0]) nv = ((v + 8'd10) > mx) ? mn : v + 8'd10;
        else         nv = (v == mx) ? mn : v + 8'd1;
      end else begin
        if (!cur[0]) nv = (v < (mn + 8'd10)) ? mx : v - 8'd10;
        else         nv = (v == mn) ? mx : v - 8'd1;
      end
      if (int'(cur >> 1) == int'(NUM_FIELDS) - 1 - i)
        r[8*i +: 8] = bin2bcd(nv[6:0]);
    end
    return r;
  endfunction

  assign l_e  = bt_left & ~prev_l;
  assign r_e  = bt_right & ~prev_r;
  assign ok_e = bt_ok & ~prev_ok;
  assign cn_e = bt_cancel & ~prev_cn;
  assign nav  = l_e | r_e;
  assign move = (state == ST_EDIT) & (l_e ^ r_e);

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
    .clk(clk), .reset(reset), .tick(tick), .btn(bt_up), .other(bt_down),
    .enable(state == ST_EDIT), .clear(move), .act_c(up_act)
  );

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dn (
    .clk(clk), .reset(reset), .tick(tick), .btn(bt_down), .other(bt_up),
    .enable(state == ST_EDIT), .clear(move), .act_c(dn_act)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      edit_data <= '0;
      snap      <= '0;
      cursor    <= '0;
      editing   <= 1'b0;
      done      <= 1'b0;
      cancelled <= 1'b0;
      prev_l    <= 1'b0;
      prev_r    <= 1'b0;
      prev_ok   <= 1'b0;
      prev_cn   <= 1'b0;
    end else begin
      state     <= state_d;
      edit_data <= data_d;
      snap      <= snap_d;
      cursor    <= cursor_d;
      editing   <= (state_d == ST_EDIT);
      done      <= (state_d == ST_DONE);
      cancelled <= (state_d == ST_CANCEL);
      prev_l    <= bt_left;
      prev_r    <= bt_right;
      prev_ok   <= bt_ok;
      prev_cn   <= bt_cancel;
    end
  end

  // Priority within EDIT: ok > cancel > left/right > up/down
  always_comb begin
    state_d  = state;
    data_d   = edit_data;
    snap_d   = snap;
    cursor_d = cursor;
    case (state)
      ST_IDLE: begin
        if (start) begin
          data_d   = sanitise(load_data);
          snap_d   = sanitise(load_data);
          cursor_d = '0;
          state_d  = ST_EDIT;
        end
      end
      ST_EDIT: begin
        if (ok_e) begin
          state_d = ST_DONE;
        end else if (cn_e) begin
          data_d  = snap;
          state_d = ST_CANCEL;
        end else if (nav) begin
          if (l_e && !r_e)      cursor_d = (cursor == '0) ? LAST : cursor - CW'(1);
          else if (r_e && !l_e) cursor_d = (cursor == LAST) ? '0 : cursor + CW'(1);
        end else if (up_act) begin
          data_d = adjust(edit_data, cursor, 1'b1);
        end else if (dn_act) begin
          data_d = adjust(edit_data, cursor, 1'b0);
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      ST_CANCEL: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bcd_field_editor.sv
// Randomised and directed bench for bcd_field_editor against a field-level reference model.
module tb_bcd_field_editor;

  localparam int NF = 3;
  localparam int D  = 6;
  localparam int R  = 3;
  localparam logic [23:0] FMAX = 24'h235959;
  localparam logic [23:0] FMIN = 24'h000000;

  logic        clk = 1'b0;
  logic        reset, tick, start;
  logic [23:0] load_data;
  logic        bt_up, bt_down, bt_left, bt_right, bt_ok, bt_cancel;
  logic [23:0] edit_data;
  logic [2:0]  cursor;
  logic        editing, done, cancelled;

  always #5 clk = ~clk;

  bcd_field_editor #(
    .NUM_FIELDS(NF), .FIELD_MAX(FMAX), .FIELD_MIN(FMIN),
    .REPEAT_DELAY(D), .REPEAT_RATE(R)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .load_data(load_data),
    .bt_up(bt_up), .bt_down(bt_down), .bt_left(bt_left), .bt_right(bt_right),
    .bt_ok(bt_ok), .bt_cancel(bt_cancel), .edit_data(edit_data), .cursor(cursor),
    .editing(editing), .done(done), .cancelled(cancelled)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: decimal field values, mode 0 idle, 1 edit, 2 done, 3 cancel
  int m_mode;
  int fld [NF];
  int snp [NF];
  int cur;
  bit p_up, p_dn, p_l, p_r, p_ok, p_cn;
  int n_up, n_dn;

  function automatic int dec(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int fmin(input int i);
    logic [23:0] t;
    t = FMIN;
    return dec(t[8*i +: 8]);
  endfunction

  function automatic int fmax(input int i);
    logic [23:0] t;
    t = FMAX;
    return dec(t[8*i +: 8]);
  endfunction

  function automatic logic [23:0] exp_data();
    logic [23:0] p;
    p = '0;
    for (int i = 0; i < NF; i++) p[8*i +: 8] = {4'(fld[i] / 10), 4'(fld[i] % 10)};
    return p;
  endfunction

  function automatic bit fires(input int n);
    return (n == D) || (n > D && ((n - D) % R) == 0);
  endfunction

  task automatic do_adjust(input bit up);
    int f, v, mn, mx;
    f  = NF - 1 - cur / 2;
    v  = fld[f];
    mn = fmin(f);
    mx = fmax(f);
    if (cur % 2 == 0) begin
      if (up) v = (v + 10 > mx) ? mn : v + 10;
      else    v = (v < mn + 10) ? mx : v - 10;
    end else begin
      if (up) v = (v == mx) ? mn : v + 1;
      else    v = (v == mn) ? mx : v - 1;
    end
    fld[f] = v;
  endtask

  task automatic model_step();
    bit e_up, e_dn, e_l, e_r, e_ok, e_cn, mv, f_up, f_dn;
    int nm;
    logic [7:0] b;
    if (reset) begin
      m_mode = 0; cur = 0; n_up = 0; n_dn = 0;
      for (int i = 0; i < NF; i++) begin fld[i] = 0; snp[i] = 0; end
      {p_up, p_dn, p_l, p_r, p_ok, p_cn} = '0;
      return;
    end
    e_up = bt_up & !p_up;  e_dn = bt_down & !p_dn;
    e_l  = bt_left & !p_l; e_r  = bt_right & !p_r;
    e_ok = bt_ok & !p_ok;  e_cn = bt_cancel & !p_cn;
    mv = e_l ^ e_r;
    f_up = 0; f_dn = 0;
    nm = m_mode;
    case (m_mode)
      0: if (start) begin
        for (int i = 0; i < NF; i++) begin
          b = load_data[8*i +: 8];
          if (b[7:4] > 9 || b[3:0] > 9 || dec(b) < fmin(i) || dec(b) > fmax(i)) fld[i] = fmin(i);
          else fld[i] = dec(b);
          snp[i] = fld[i];
        end
        cur = 0;
        nm = 1;
      end
      1: begin
        if (bt_up && !bt_down && !mv) begin
          if (tick) n_up++;
          f_up = tick && fires(n_up);
        end else n_up = 0;
        if (bt_down && !bt_up && !mv) begin
          if (tick) n_dn++;
          f_dn = tick && fires(n_dn);
        end else n_dn = 0;
        if (e_ok) nm = 2;
        else if (e_cn) begin
          for (int i = 0; i < NF; i++) fld[i] = snp[i];
          nm = 3;
        end else if (e_l || e_r) begin
          if (e_l && !e_r) cur = (cur == 0) ? 2 * NF - 1 : cur - 1;
          else if (e_r && !e_l) cur = (cur == 2 * NF - 1) ? 0 : cur + 1;
        end else if (!bt_down && (e_up || f_up)) do_adjust(1);
        else if (!bt_up && (e_dn || f_dn)) do_adjust(0);
      end
      default: nm = 0;
    endcase
    if (nm != 1) begin n_up = 0; n_dn = 0; end
    m_mode = nm;
    p_up = bt_up; p_dn = bt_down; p_l = bt_left; p_r = bt_right; p_ok = bt_ok; p_cn = bt_cancel;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("edit_data", 32'(edit_data), 32'(exp_data()));
    chk("cursor",    32'(cursor),    32'(cur));
    chk("editing",   32'(editing),   32'(m_mode == 1));
    chk("done",      32'(done),      32'(m_mode == 2));
    chk("cancelled", 32'(cancelled), 32'(m_mode == 3));
  endtask

  task automatic clr_inputs();
    {tick, start, bt_up, bt_down, bt_left, bt_right, bt_ok, bt_cancel} = '0;
  endtask

  task automatic pulse_up();   bt_up = 1;    cyc(); bt_up = 0;    cyc(); endtask
  task automatic pulse_dn();   bt_down = 1;  cyc(); bt_down = 0;  cyc(); endtask
  task automatic pulse_l();    bt_left = 1;  cyc(); bt_left = 0;  cyc(); endtask
  task automatic pulse_r();    bt_right = 1; cyc(); bt_right = 0; cyc(); endtask

  task automatic load(input logic [23:0] v);
    load_data = v; start = 1; cyc(); start = 0; cyc();
  endtask

  initial begin
    clr_inputs();
    load_data = '0;
    reset = 1;
    cyc(); cyc();
    chk("rst_data", 32'(edit_data), 32'h0);
    chk("rst_editing", 32'(editing), 32'h0);
    reset = 0;

    // Hours field arithmetic with wrap in both directions
    load(24'h123456);
    chk("t1_load", 32'(edit_data), 32'h123456);
    pulse_up();  chk("t1_up", 32'(edit_data), 32'h223456);
    pulse_up();  chk("t1_upwrap", 32'(edit_data), 32'h003456);
    pulse_dn();  chk("t1_dnwrap", 32'(edit_data), 32'h233456);

    // Cursor wrap and same-cycle conflicts
    pulse_l();   chk("t2_left", 32'(cursor), 32'd5);
    pulse_r();   chk("t2_right", 32'(cursor), 32'd0);
    bt_left = 1; bt_right = 1; cyc(); bt_left = 0; bt_right = 0; cyc();
    chk("t2_lr", 32'(cursor), 32'd0);
    bt_right = 1; bt_up = 1; cyc(); bt_right = 0; bt_up = 0; cyc();
    chk("t2_rup_cur", 32'(cursor), 32'd1);
    chk("t2_rup_data", 32'(edit_data), 32'h233456);
    bt_ok = 1; cyc(); bt_ok = 0; cyc(); cyc();

    // Minutes and seconds wrap from zero
    load(24'h000000);
    pulse_r(); pulse_r(); pulse_r();
    pulse_dn();  chk("t3_min", 32'(edit_data), 32'h005900);
    pulse_r();
    pulse_dn();  chk("t3_sectens", 32'(edit_data), 32'h005959);
    pulse_r();
    pulse_up();  chk("t3_secwrap", 32'(edit_data), 32'h005900);
    bt_cancel = 1; cyc(); bt_cancel = 0; cyc(); cyc();

    // Auto-repeat timing, then both buttons held
    load(24'h000058);
    pulse_l();
    bt_up = 1; cyc();
    chk("t4_edge", 32'(edit_data), 32'h000059);
    tick = 1;
    for (int i = 0; i < D; i++) cyc();
    chk("t4_delay", 32'(edit_data), 32'h000000);
    for (int i = 0; i < R; i++) cyc();
    chk("t4_rate", 32'(edit_data), 32'h000001);
    tick = 0; bt_up = 0; cyc();
    bt_up = 1; bt_down = 1; tick = 1;
    for (int i = 0; i < 2 * D; i++) cyc();
    chk("t4_both", 32'(edit_data), 32'h000001);
    tick = 0; bt_up = 0; bt_down = 0; cyc();

    // Cancel restores the loaded value
    bt_cancel = 1; cyc();
    chk("t5_cancel_pulse", 32'(cancelled), 32'h1);
    chk("t5_cancel_data", 32'(edit_data), 32'h000058);
    bt_cancel = 0; cyc();
    chk("t5_cancel_end", 32'(cancelled), 32'h0);

    // Commit an edited value
    load(24'h000000);
    pulse_up(); pulse_r(); pulse_up();
    bt_ok = 1; cyc();
    chk("t5_done_pulse", 32'(done), 32'h1);
    chk("t5_done_data", 32'(edit_data), 32'h110000);
    bt_ok = 0; cyc();
    chk("t5_done_end", 32'(done), 32'h0);
    chk("t5_hold_data", 32'(edit_data), 32'h110000);

    // Sanitising, start ignored while editing, reset mid-edit
    load(24'h256A30);
    chk("t6_sanitise", 32'(edit_data), 32'h000030);
    load_data = 24'h123456; start = 1;
    pulse_up();
    start = 0;
    chk("t6_start_ign", 32'(edit_data), 32'h100030);
    reset = 1; cyc(); reset = 0;
    chk("t6_rst_data", 32'(edit_data), 32'h0);
    chk("t6_rst_flags", 32'({editing, done, cancelled}), 32'h0);
    cyc();

    // Random stimulus against the model
    for (int n = 0; n < 4000; n++) begin
      tick = ($urandom % 3) == 0;
      start = ($urandom % 8) == 0;
      if ($urandom % 2) load_data = 24'($urandom);
      else load_data = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                        4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                        4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      if ($urandom % 16 == 0) bt_up = ~bt_up;
      if ($urandom % 16 == 0) bt_down = ~bt_down;
      if ($urandom % 6 == 0)  bt_left = ~bt_left;
      if ($urandom % 6 == 0)  bt_right = ~bt_right;
      if ($urandom % 50 == 0) bt_ok = ~bt_ok;
      if ($urandom % 60 == 0) bt_cancel = ~bt_cancel;
      reset = ($urandom % 400) == 0;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
